wb_rr_arbiter: RTL and testbench
================================

# wb_rr_arbiter

Two-master, two-slave Wishbone B3 classic shared-bus arbiter with round-robin grant, address decode and decode-error response. It sits between the core complex and the slave set, for example memory_wb and leds. It lets a second bus master, such as a DMA engine or second core port, share the memory and peripheral slaves. Both slaves see a single granted master at a time.

## Interface
- WB_DWIDTH, 32, data width
- WB_SWIDTH, 4, byte-select width
- S0_REGION, 4'h0, value of adr[31:28] that selects slave 0
- S1_REGION, 4'h1, value of adr[31:28] that selects slave 1
- TIMEOUT, 255, watchdog limit in cycles; 8-bit counter, legal range 1–255
- i_clk  in  1  bus clock
- i_arst_n  in  1  asynchronous active-low reset
- i_mX_wb_cyc / i_mX_wb_stb / i_mX_wb_we  in  1 each  master X (X = 0, 1) cycle, strobe, write-enable
- i_mX_wb_adr  in  32  master X address
- i_mX_wb_sel  in  WB_SWIDTH  master X byte selects
- i_mX_wb_dat  in  WB_DWIDTH  master X write data
- o_mX_wb_dat  out  WB_DWIDTH  master X read data
- o_mX_wb_ack / o_mX_wb_err  out  1 each  master X acknowledge, error
- o_sY_wb_cyc / o_sY_wb_stb / o_sY_wb_we  out  1 each  slave Y (Y = 0, 1) cycle, strobe, write-enable
- o_sY_wb_adr / o_sY_wb_sel / o_sY_wb_dat  out  32 / WB_SWIDTH / WB_DWIDTH  slave Y address, byte selects, write data
- i_sY_wb_dat  in  WB_DWIDTH  slave Y read data
- i_sY_wb_ack  in  1  slave Y acknowledge
- o_grant  out  2  one-hot registered grant; 2'b00 when idle

## Operation
- FSM states:
  - IDLE: no grant.
  - OWN0: master 0 owns the bus.
  - OWN1: master 1 owns the bus.
- IDLE -> OWNx when i_mx_wb_cyc is high.
- If both masters request, grant the master that was not granted last.
  - Priority pointer `last` resets to 1, so master 0 wins the first tie.
- OWNx holds while i_mx_wb_cyc is high; this is a bus lock across any number of strobes.
- OWNx -> IDLE on i_mx_wb_cyc low. Update `last` to x on that transition.
- Address decode (owner's adr[31:28]):
  - Equals S0_REGION: slave 0 hit.
  - Equals S1_REGION: slave 1 hit.
  - Otherwise: miss.
- Slave outputs:
  - adr, sel, we and dat are the owner's values, broadcast to both slaves; all zero in IDLE.
  - o_sY_wb_cyc = owner cyc AND slave Y hit. o_sY_wb_stb likewise.
  - All slave cyc/stb are 0 in IDLE.
- Master outputs:
  - Owner receives i_sY_wb_dat and i_sY_wb_ack of its hit slave, combinationally.
  - Non-owner dat, ack and err are 0.
  - Owner dat is 0 on a miss.
- Decode error:
  - Owner stb with a miss raises a registered err, one cycle after stb.
  - Err is a single pulse; err_q is set only if it was clear.
  - No slave strobe is raised on a miss.
- Slave ack arriving for a non-owner or while IDLE is ignored.

## Timing
- Reset: all outputs 0, FSM IDLE, `last` = 1, counters 0. Reset is asynchronous and valid mid-transfer; the slave strobe drops immediately.
- Grant latency:
  - Cycle 0: cyc is seen in IDLE.
  - Cycle 1: OWNx registered, o_grant valid, slave cyc/stb driven.
  - Minimum zero-wait read: stb in cycle 1, slave ack in cycle 1, ack to master in cycle 1.
- Release:
  - Owner drops cyc in cycle N -> IDLE in cycle N+1.
  - A pending request is granted in cycle N+2.
  - There is one mandatory idle cycle between owners.
- Simultaneous requests in IDLE: round-robin decides. With both masters holding cyc continuously, grants alternate.
- Owner may change address between strobes; decode follows the current address every cycle.

## Configuration
- WB_TIMEOUT_EN defined:
  - An 8-bit watchdog counts cycles while owner stb is high and a slave is hit without ack.
  - The counter clears on ack, on stb low or on grant change.
  - On reaching TIMEOUT: o_mx_wb_err pulses for one cycle, slave cyc/stb are forced low for that cycle, and the counter clears.
  - If ack and timeout coincide in the same cycle, ack wins and no err is raised.
- WB_TIMEOUT_EN undefined:
  - No counter is built.
  - A hung slave stalls the owner indefinitely.
  - err is raised only on decode miss.

## Test plan
- Reset, then m0 reads adr 0x0000_0010 while s0 acks in the same cycle with data 0xDEADBEEF.
  -> o_grant = 01 one cycle after cyc; o_m0_wb_dat = 0xDEADBEEF with ack; o_s1_wb_stb stays 0.
- m0 and m1 raise cyc in the same cycle, each performing one transfer then dropping cyc, repeated 4 times.
  -> grant order m0, m1, m0, m1; one idle cycle between owners; the non-owner never sees ack.
- m1 writes 0x1234_5678 to adr 0x1000_0004 with sel = 4'b0011.
  -> s1 sees stb, we = 1, dat 0x12345678, sel 0011; s0 cyc stays 0.
- m0 strobes adr 0xF000_0000.
  -> err pulses 1 cycle later, no slave stb, ack stays 0.
- With WB_TIMEOUT_EN and TIMEOUT = 8, s0 never acks.
  -> o_m0_wb_err pulses exactly 8 cycles after stb rises; without the macro, no err appears in 300 cycles.
- i_arst_n is pulsed low mid-transfer while OWN1.
  -> all outputs 0 asynchronously; the next simultaneous request is granted to m0.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Two-master / two-slave Wishbone B3 classic shared-bus arbiter with round-robin grant,
// adr[31:28] region decode and decode-error response. Define WB_TIMEOUT_EN for the slave-ack watchdog.
module wb_rr_arbiter #(
  parameter int unsigned WB_DWIDTH = 32,
  parameter int unsigned WB_SWIDTH = 4,
  parameter logic [3:0]  S0_REGION = 4'h0,
  parameter logic [3:0]  S1_REGION = 4'h1,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 i_clk,
  input  logic                 i_arst_n,
  input  logic                 i_m0_wb_cyc,
  input  logic                 i_m0_wb_stb,
  input  logic                 i_m0_wb_we,
  input  logic [31:0]          i_m0_wb_adr,
  input  logic [WB_SWIDTH-1:0] i_m0_wb_sel,
  input  logic [WB_DWIDTH-1:0] i_m0_wb_dat,
  output logic [WB_DWIDTH-1:0] o_m0_wb_dat,
  output logic                 o_m0_wb_ack,
  output logic                 o_m0_wb_err,
  input  logic                 i_m1_wb_cyc,
  input  logic                 i_m1_wb_stb,
  input  logic                 i_m1_wb_we,
  input  logic [31:0]          i_m1_wb_adr,
  input  logic [WB_SWIDTH-1:0] i_m1_wb_sel,
  input  logic [WB_DWIDTH-1:0] i_m1_wb_dat,
  output logic [WB_DWIDTH-1:0] o_m1_wb_dat,
  output logic                 o_m1_wb_ack,
  output logic                 o_m1_wb_err,
  output logic                 o_s0_wb_cyc,
  output logic                 o_s0_wb_stb,
  output logic                 o_s0_wb_we,
  output logic [31:0]          o_s0_wb_adr,
  output logic [WB_SWIDTH-1:0] o_s0_wb_sel,
  output logic [WB_DWIDTH-1:0] o_s0_wb_dat,
  input  logic [WB_DWIDTH-1:0] i_s0_wb_dat,
  input  logic                 i_s0_wb_ack,
  output logic                 o_s1_wb_cyc,
  output logic                 o_s1_wb_stb,
  output logic                 o_s1_wb_we,
  output logic [31:0]          o_s1_wb_adr,
  output logic [WB_SWIDTH-1:0] o_s1_wb_sel,
  output logic [WB_DWIDTH-1:0] o_s1_wb_dat,
  input  logic [WB_DWIDTH-1:0] i_s1_wb_dat,
  input  logic                 i_s1_wb_ack,
  output logic [1:0]           o_grant
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 8;

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

  state_t                 state;
  logic                   last;
  logic                   err_q;
  logic                   own_cyc, own_stb, own_we;
  logic [AW-1:0]          own_adr;
  logic [WB_SWIDTH-1:0]   own_sel;
  logic [WB_DWIDTH-1:0]   own_dat;
  logic [3:0]             region;
  logic                   hit0, hit1, miss;
  logic                   sel_ack;
  logic [WB_DWIDTH-1:0]   sel_dat;
  logic                   tmo;
  logic                   release_c;

  // Owner request mux; everything reads as zero while idle.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_sel = '0;
    own_dat = '0;
    case (state)
      OWN0: begin
        own_cyc = i_m0_wb_cyc;
        own_stb = i_m0_wb_stb;
        own_we  = i_m0_wb_we;
        own_adr = i_m0_wb_adr;
        own_sel = i_m0_wb_sel;
        own_dat = i_m0_wb_dat;
      end
      OWN1: begin
        own_cyc = i_m1_wb_cyc;
        own_stb = i_m1_wb_stb;
        own_we  = i_m1_wb_we;
        own_adr = i_m1_wb_adr;
        own_sel = i_m1_wb_sel;
        own_dat = i_m1_wb_dat;
      end
      default: ;
    endcase
  end

  assign region    = own_adr[AW-1:AW-4];
  assign hit0      = (state != IDLE) && (region == S0_REGION);
  assign hit1      = (state != IDLE) && !hit0 && (region == S1_REGION);
  assign miss      = !hit0 && !hit1;
  assign sel_ack   = (hit0 & i_s0_wb_ack) | (hit1 & i_s1_wb_ack);
  assign sel_dat   = hit0 ? i_s0_wb_dat : (hit1 ? i_s1_wb_dat : '0);
  assign release_c = (state != IDLE) && !own_cyc;

`ifdef WB_TIMEOUT_EN
  logic [CW-1:0] cnt;
  logic          count_en;

  assign tmo      = own_stb && (hit0 || hit1) && (cnt == CW'(TIMEOUT));
  assign count_en = own_stb && (hit0 || hit1) && !sel_ack && !tmo && !release_c;

  // Watchdog: counts unacknowledged strobe cycles of the current owner.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) cnt <= '0;
    else           cnt <= count_en ? cnt + CW'(1) : '0;
  end
`else
  assign tmo = 1'b0;
`endif

  // Grant FSM with round-robin pointer and single-pulse decode error.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      err_q <= 1'b0;
    end else begin
      err_q <= own_stb & miss & ~err_q;
      case (state)
        IDLE: begin
          if (i_m0_wb_cyc && (!i_m1_wb_cyc || last)) state <= OWN0;
          else if (i_m1_wb_cyc)                      state <= OWN1;
        end
        OWN0: if (!i_m0_wb_cyc) begin
          state <= IDLE;
          last  <= 1'b0;
        end
        OWN1: if (!i_m1_wb_cyc) begin
          state <= IDLE;
          last  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_grant = state;

  assign o_s0_wb_cyc = own_cyc & hit0 & ~tmo;
  assign o_s0_wb_stb = own_stb & hit0 & ~tmo;
  assign o_s1_wb_cyc = own_cyc & hit1 & ~tmo;
  assign o_s1_wb_stb = own_stb & hit1 & ~tmo;
  assign o_s0_wb_we  = own_we;
  assign o_s0_wb_adr = own_adr;
  assign o_s0_wb_sel = own_sel;
  assign o_s0_wb_dat = own_dat;
  assign o_s1_wb_we  = own_we;
  assign o_s1_wb_adr = own_adr;
  assign o_s1_wb_sel = own_sel;
  assign o_s1_wb_dat = own_dat;

  // Ack on the same cycle as a watchdog expiry takes precedence over the error.
  assign o_m0_wb_dat = (state == OWN0) ? sel_dat : '0;
  assign o_m0_wb_ack = (state == OWN0) & sel_ack;
  assign o_m0_wb_err = (state == OWN0) & (err_q | (tmo & ~sel_ack));
  assign o_m1_wb_dat = (state == OWN1) ? sel_dat : '0;
  assign o_m1_wb_ack = (state == OWN1) & sel_ack;
  assign o_m1_wb_err = (state == OWN1) & (err_q | (tmo & ~sel_ack));

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomized + directed bench for wb_rr_arbiter against a behavioural bus-ownership model.
// Honors WB_TIMEOUT_EN the same way as the design (watchdog limit 8 here).
module tb_wb_rr_arbiter;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = 4;
  localparam int          TMO = 8;
  localparam int unsigned MW  = DW + 2;
  localparam int unsigned SLW = 3 + 32 + SW + DW;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]    m_cyc, m_stb, m_we;
  logic [31:0]   m_adr  [2];
  logic [SW-1:0] m_sel  [2];
  logic [DW-1:0] m_wdat [2];
  logic [DW-1:0] m_rdat [2];
  logic [1:0]    m_ack, m_err;
  logic [1:0]    s_cyc, s_stb, s_we;
  logic [31:0]   s_adr  [2];
  logic [SW-1:0] s_sel  [2];
  logic [DW-1:0] s_wdat [2];
  logic [DW-1:0] s_rdat [2];
  logic [1:0]    s_ack;
  logic [1:0]    grant;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.WB_DWIDTH(DW), .WB_SWIDTH(SW), .S0_REGION(4'h0), .S1_REGION(4'h1),
                  .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_m0_wb_cyc(m_cyc[0]), .i_m0_wb_stb(m_stb[0]), .i_m0_wb_we(m_we[0]),
    .i_m0_wb_adr(m_adr[0]), .i_m0_wb_sel(m_sel[0]), .i_m0_wb_dat(m_wdat[0]),
    .o_m0_wb_dat(m_rdat[0]), .o_m0_wb_ack(m_ack[0]), .o_m0_wb_err(m_err[0]),
    .i_m1_wb_cyc(m_cyc[1]), .i_m1_wb_stb(m_stb[1]), .i_m1_wb_we(m_we[1]),
    .i_m1_wb_adr(m_adr[1]), .i_m1_wb_sel(m_sel[1]), .i_m1_wb_dat(m_wdat[1]),
    .o_m1_wb_dat(m_rdat[1]), .o_m1_wb_ack(m_ack[1]), .o_m1_wb_err(m_err[1]),
    .o_s0_wb_cyc(s_cyc[0]), .o_s0_wb_stb(s_stb[0]), .o_s0_wb_we(s_we[0]),
    .o_s0_wb_adr(s_adr[0]), .o_s0_wb_sel(s_sel[0]), .o_s0_wb_dat(s_wdat[0]),
    .i_s0_wb_dat(s_rdat[0]), .i_s0_wb_ack(s_ack[0]),
    .o_s1_wb_cyc(s_cyc[1]), .o_s1_wb_stb(s_stb[1]), .o_s1_wb_we(s_we[1]),
    .o_s1_wb_adr(s_adr[1]), .o_s1_wb_sel(s_sel[1]), .o_s1_wb_dat(s_wdat[1]),
    .i_s1_wb_dat(s_rdat[1]), .i_s1_wb_ack(s_ack[1]),
    .o_grant(grant)
  );

  // ---------------- behavioural model ----------------
  int own;   // -1 = nobody owns the bus
  int last;  // master granted most recently
  bit errq;  // decode-error pulse pending for the owner
  int cnt;   // unacknowledged strobe cycles

  function automatic int hit_of(input logic [31:0] a);
    if (a[31:28] == 4'h0) return 0;
    if (a[31:28] == 4'h1) return 1;
    return -1;
  endfunction

  function automatic int cur_hit();
    return (own < 0) ? -1 : hit_of(m_adr[own]);
  endfunction

  function automatic bit cur_sack();
    int h;
    h = cur_hit();
    return (h < 0) ? 1'b0 : s_ack[h];
  endfunction

  function automatic bit cur_tmo();
`ifdef WB_TIMEOUT_EN
    return (own >= 0) && m_stb[own] && (cur_hit() >= 0) && (cnt == TMO);
`else
    return 1'b0;
`endif
  endfunction

  int mh, nown;
  bit msa, mt, errq_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own = -1; last = 1; errq = 0; cnt = 0;
    end else begin
      mh = cur_hit(); msa = cur_sack(); mt = cur_tmo();
      nown = own;
      if (own < 0) begin
        if (m_cyc == 2'b11)  nown = (last == 1) ? 0 : 1;
        else if (m_cyc[0])   nown = 0;
        else if (m_cyc[1])   nown = 1;
      end else if (!m_cyc[own]) begin
        nown = -1;
        last = own;
      end
      errq_n = (own >= 0) && m_stb[own] && (mh < 0) && !errq;
      cnt = ((own >= 0) && (nown == own) && m_stb[own] && (mh >= 0) && !msa && !mt) ? cnt + 1 : 0;
      errq = errq_n;
      own = nown;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [1:0]       eg;
  logic [2*MW-1:0]  em, am;
  logic [2*SLW-1:0] es, as_;
  int ch;
  bit csa, ct;

  always @(negedge clk) begin
    ch = cur_hit(); csa = cur_sack(); ct = cur_tmo();
    eg = (own == 0) ? 2'b01 : ((own == 1) ? 2'b10 : 2'b00);
    em = '0; es = '0;
    for (int x = 0; x < 2; x++) begin
      if (own == x)
        em[x*MW +: MW] = {((ch < 0) ? 32'h0 : s_rdat[ch]), csa, (errq | (ct & !csa))};
      am[x*MW +: MW] = {m_rdat[x], m_ack[x], m_err[x]};
    end
    for (int y = 0; y < 2; y++) begin
      if (own >= 0)
        es[y*SLW +: SLW] = {(m_cyc[own] && ch == y && !ct), (m_stb[own] && ch == y && !ct),
                            m_we[own], m_adr[own], m_sel[own], m_wdat[own]};
      as_[y*SLW +: SLW] = {s_cyc[y], s_stb[y], s_we[y], s_adr[y], s_sel[y], s_wdat[y]};
    end
    checks += 3;
    if (grant !== eg) begin
      failures++;
      $display("FAIL model_grant t=%0t actual=%b expected=%b", $time, grant, eg);
    end
    if (am !== em) begin
      failures++;
      $display("FAIL model_master t=%0t actual=%h expected=%h", $time, am, em);
    end
    if (as_ !== es) begin
      failures++;
      $display("FAIL model_slave t=%0t actual=%h expected=%h", $time, as_, es);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; s_ack = '0;
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = '0; m_sel[i] = '0; m_wdat[i] = '0; s_rdat[i] = '0;
    end
  endtask

  task automatic rr_rounds(input int rounds);
    int seq[$];
    logic [1:0] prev;
    int bad_idle, bad_ack, budget;
    bit p0, p1;
    prev = 2'b00; bad_idle = 0; bad_ack = 0;
    m_adr[0] = 32'h0000_0000; m_adr[1] = 32'h1000_0000;
    s_ack = 2'b11; s_rdat[0] = 32'hA0A0_0000; s_rdat[1] = 32'hB1B1_1111;
    for (int r = 0; r < rounds; r++) begin
      p0 = 1; p1 = 1; budget = 0;
      while ((p0 || p1 || grant != 2'b00) && budget < 40) begin
        tick();
        m_cyc[0] = p0; m_stb[0] = p0; m_cyc[1] = p1; m_stb[1] = p1;
        @(negedge clk);
        budget++;
        if (grant != 2'b00 && grant != prev) seq.push_back((grant == 2'b01) ? 0 : 1);
        if (prev != 2'b00 && grant != 2'b00 && grant != prev) bad_idle++;
        if ((m_ack[0] && grant != 2'b01) || (m_ack[1] && grant != 2'b10)) bad_ack++;
        if (m_ack[0]) p0 = 0;
        if (m_ack[1]) p1 = 0;
        prev = grant;
      end
      chk($sformatf("rr_round%0d_done", r), {p0, p1}, 0);
    end
    chk("rr_grant_count", seq.size(), 2 * rounds);
    for (int i = 0; i < seq.size(); i++) chk($sformatf("rr_order%0d", i), seq[i], i % 2);
    chk("rr_idle_between", bad_idle, 0);
    chk("rr_nonowner_ack", bad_ack, 0);
    idle_inputs();
  endtask

  // ---------------- stimulus ----------------
  int n, errs;
  logic [3:0] rg;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset_grant", grant, 0);
    chk("reset_s0_stb", s_stb[0], 0);
    chk("reset_m0_ack", m_ack[0], 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // simultaneous requests, one transfer each, four rounds
    rr_rounds(4);
    tick();

    // zero-wait read by m0 from slave 0
    tick();
    m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 32'h0000_0010;
    s_ack = 2'b11; s_rdat[0] = 32'hDEAD_BEEF; s_rdat[1] = 32'h0000_0055;
    @(negedge clk);
    chk("rd_grant_cycle0", grant, 2'b00);
    tick(); @(negedge clk);
    chk("rd_grant_cycle1", grant, 2'b01);
    chk("rd_m0_dat", m_rdat[0], 32'hDEAD_BEEF);
    chk("rd_m0_ack", m_ack[0], 1);
    chk("rd_s1_stb", s_stb[1], 0);
    tick(); idle_inputs();
    tick();

    // m1 write to slave 1
    tick();
    m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 1; m_adr[1] = 32'h1000_0004;
    m_sel[1] = 4'b0011; m_wdat[1] = 32'h1234_5678; s_ack[1] = 1;
    tick(); @(negedge clk);
    chk("wr_s1_stb", s_stb[1], 1);
    chk("wr_s1_we", s_we[1], 1);
    chk("wr_s1_dat", s_wdat[1], 32'h1234_5678);
    chk("wr_s1_sel", s_sel[1], 4'b0011);
    chk("wr_s0_cyc", s_cyc[0], 0);
    tick(); idle_inputs();
    tick();

    // decode miss from m0
    tick();
    m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 32'hF000_0000; s_ack = 2'b11;
    tick(); @(negedge clk);
    chk("miss_err_early", m_err[0], 0);
    chk("miss_no_stb", {s_stb[1], s_stb[0]}, 0);
    tick(); @(negedge clk);
    chk("miss_err_pulse", m_err[0], 1);
    chk("miss_ack", m_ack[0], 0);
    tick(); m_cyc[0] = 0; m_stb[0] = 0;
    @(negedge clk);
    chk("miss_err_single", m_err[0], 0);
    idle_inputs();
    tick();

    // hung slave 0
    tick();
    m_cyc[0] = 1; m_adr[0] = 32'h0000_0020;
    tick(); m_stb[0] = 1;
    @(negedge clk);
`ifdef WB_TIMEOUT_EN
    n = 0;
    while (!m_err[0] && n < 20) begin
      tick(); @(negedge clk);
      n++;
    end
    chk("tmo_latency", n, TMO);
    chk("tmo_slave_stb_forced", s_stb[0], 0);
    tick(); m_cyc[0] = 0; m_stb[0] = 0;
    @(negedge clk);
    chk("tmo_err_single", m_err[0], 0);
`else
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      tick(); @(negedge clk);
      if (m_err[0]) errs++;
    end
    chk("hung_no_err", errs, 0);
    chk("hung_still_strobed", s_stb[0], 1);
    tick(); m_cyc[0] = 0; m_stb[0] = 0;
`endif
    idle_inputs();
    tick();

    // asynchronous reset while m1 owns the bus
    tick();
    m_cyc[1] = 1; m_stb[1] = 1; m_adr[1] = 32'h1000_0008;
    tick(); @(negedge clk);
    chk("arst_owner_before", grant, 2'b10);
    chk("arst_s1_stb_before", s_stb[1], 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_s1_stb", s_stb[1], 0);
    chk("arst_s1_adr", s_adr[1], 0);
    m_cyc = 2'b11; m_stb = 2'b11; m_adr[0] = 32'h0000_0000;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_after", grant, 2'b00);
    tick(); @(negedge clk);
    chk("arst_tie_to_m0", grant, 2'b01);
    idle_inputs();
    repeat (3) tick();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      tick();
      for (int x = 0; x < 2; x++) begin
        if ($urandom_range(7) == 0) m_cyc[x] = ~m_cyc[x];
        m_stb[x] = m_cyc[x] & 1'($urandom_range(1));
        case ($urandom_range(3))
          0: rg = 4'h0;
          1: rg = 4'h1;
          2: rg = 4'hF;
          default: rg = 4'($urandom);
        endcase
        m_adr[x]  = {rg, 28'($urandom)};
        m_we[x]   = 1'($urandom);
        m_sel[x]  = SW'($urandom);
        m_wdat[x] = DW'($urandom);
        s_ack[x]  = ($urandom_range(2) == 0);
        s_rdat[x] = DW'($urandom);
      end
    end
    idle_inputs();
    repeat (4) tick();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench did not finish");
  end

endmodule
